floor_report_tx: RTL
====================

Name: floor_report_tx

Overview:
- Sequences the 7-segment-to-ASCII encoder datapath into a serial byte stream that reports the displayed floor number.
- Watches the 14-bit two-digit segment bus and snapshots it when it changes or when a report is forced.
- Emits a fixed frame over a valid/ready byte interface toward the UART transmitter: PREFIX, high digit, low digit, then optionally CR and LF.
- Enforces a minimum idle gap between frames.

Parameters:
- PREFIX, 8'h46, first byte of every frame ('F').
- SEND_CRLF, 1, 1 = append 8'h0D, 8'h0A (5-byte frame); 0 = 3-byte frame.
- GAP_CYCLES, 16, idle clocks required after the last byte of a frame before the next frame may start; range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ssIn  in  14  segment bus; [13:7] high digit, [6:0] low digit, a..g MSB-first.
- forceReq  in  1  one-cycle pulse; requests a frame even if ssIn is unchanged.
- txData  out  8  byte to transmitter.
- txValid  out  1  txData valid.
- txReady  in  1  transmitter accepts byte when txValid && txReady at a clock edge.
- busy  out  1  high in any state other than IDLE.
- frameCount  out  8  number of completed frames, wraps 255→0.

Behaviour:
- Reset (synchronous): state=IDLE; txValid=0; txData=8'h00; busy=0; frameCount=0; pending=0; prevSs=14'h0000; snapshot=0; gap counter=0.
- Change detect: every cycle the block compares ssIn to prevSs. If they differ, or forceReq=1, it sets pending=1 and loads prevSs<=ssIn.
- States:
  - IDLE: if pending (or a request arrives this cycle), load snapshot<=ssIn, clear pending, set byte index=0, and go to SEND. txValid rises on the next cycle with txData=PREFIX. Latency from change edge to first txValid is 1 clock.
  - SEND: presents byte[index]:
    - 0 = PREFIX
    - 1 = ASCII(snapshot[13:7])
    - 2 = ASCII(snapshot[6:0])
    - 3 = 8'h0D
    - 4 = 8'h0A
  - On txValid&&txReady, index increments and the next byte appears in the following cycle, so back-to-back transfers run at one byte per clock when txReady is held high.
  - After the last byte is accepted: txValid=0, frameCount increments, and the block goes to GAP. If GAP_CYCLES=0 it goes directly to IDLE.
  - GAP: counts GAP_CYCLES clocks with txValid=0, then goes to IDLE.
- ASCII mapping uses the encoder unchanged:
  - Digit patterns 0..9 map to 8'h30..8'h39.
  - Any other 7-bit pattern, including blank, maps to 8'h30.
- Handshake rules:
  - txValid never depends on txReady combinationally.
  - While txValid && !txReady, txData and txValid hold stable.
  - Once txValid rises it stays high until the frame ends.
- The snapshot is frozen for the whole frame. ssIn changes during SEND/GAP set pending only. Multiple changes collapse into a single follow-up frame carrying the value sampled when that frame starts (latest ssIn).
- forceReq coinciding with an ssIn change: one request only.
- forceReq during SEND/GAP: sets pending; the frame follows after GAP.
- frameCount 255 + 1 → 0.
- Reset asserted mid-frame: the frame is aborted immediately, and txValid=0 in the cycle after the reset edge. No partial-frame completion; frameCount is not incremented (it is cleared).

Decomposition:
- Shared package holds:
  - ASCII constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_ZERO=8'h30.
  - State encoding typedef (IDLE, SEND, GAP).
  - Frame byte-index constants.
- One sub-module: segment_encoder, instantiated once on the snapshot register. Its asciOutHigh/asciOutLow outputs feed byte indices 1 and 2.

Test Plan:
- Reset release, ssIn={7'b1111110,7'b0110000} ("01"), txReady=1 → txValid high for 5 consecutive cycles with bytes 46,30,31,0D,0A; frameCount=1; busy low 16 cycles after the last byte.
- Same stimulus with txReady toggling 1,0,0,1,… → txData held stable during stalls; same 5 bytes in order; no byte duplicated or dropped.
- Change ssIn to "23" then "45" during SEND of the "01" frame → exactly two frames total: "01" then 46,34,35,0D,0A. The second frame's first byte appears no earlier than 16 idle cycles after the first frame's LF.
- ssIn low digit = 7'b0000001 (invalid), high digit = "7" → bytes 46,37,30,0D,0A.
- forceReq pulse with unchanged ssIn; then reset asserted after the 2nd byte of a frame → the forced frame starts one cycle after the pulse; after reset, txValid=0, frameCount=0, and no further bytes appear until the next change.
- SEND_CRLF=0, GAP_CYCLES=0; 256 forced frames → 3-byte frames back-to-back with one IDLE cycle between them; frameCount wraps to 0.

Source files
------------

// File: rtl/floor_report_tx_pkg.sv
// Shared constants and types for the floor-report byte framer.
// Holds the ASCII control characters, the framer state encoding and the
// byte positions inside a frame, plus the frame byte selector.
package floor_report_tx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned GAP_W  = 8;

  localparam logic [BYTE_W-1:0] CHAR_CR   = 8'h0D;
  localparam logic [BYTE_W-1:0] CHAR_LF   = 8'h0A;
  localparam logic [BYTE_W-1:0] CHAR_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_PREFIX = 3'd0;
  localparam logic [IDX_W-1:0] IDX_HIGH   = 3'd1;
  localparam logic [IDX_W-1:0] IDX_LOW    = 3'd2;
  localparam logic [IDX_W-1:0] IDX_CR     = 3'd3;
  localparam logic [IDX_W-1:0] IDX_LF     = 3'd4;

  // Byte presented at a given frame position.
  function automatic logic [BYTE_W-1:0] frame_byte(
    input logic [IDX_W-1:0]  idx,
    input logic [BYTE_W-1:0] prefix,
    input logic [BYTE_W-1:0] high,
    input logic [BYTE_W-1:0] low
  );
    case (idx)
      IDX_PREFIX: frame_byte = prefix;
      IDX_HIGH:   frame_byte = high;
      IDX_LOW:    frame_byte = low;
      IDX_CR:     frame_byte = CHAR_CR;
      IDX_LF:     frame_byte = CHAR_LF;
      default:    frame_byte = '0;
    endcase
  endfunction

endpackage

// File: rtl/floor_report_tx_segment_encoder.sv
// Two-digit 7-segment to ASCII encoder.
// Ports:
//   ssIn        - 14-bit segment bus, [13:7] high digit, [6:0] low digit,
//                 segments a..g MSB-first
//   asciOutHigh - ASCII of the high digit
//   asciOutLow  - ASCII of the low digit
// Unrecognised patterns (including blank) encode as '0'.
module segment_encoder
  import floor_report_tx_pkg::*;
(
  input  logic [2*SEG_W-1:0] ssIn,
  output logic [BYTE_W-1:0]  asciOutHigh,
  output logic [BYTE_W-1:0]  asciOutLow
);

  function automatic logic [BYTE_W-1:0] seg_to_ascii(input logic [SEG_W-1:0] seg);
    logic [3:0] digit;
    case (seg)
      7'b1111110: digit = 4'd0;
      7'b0110000: digit = 4'd1;
      7'b1101101: digit = 4'd2;
      7'b1111001: digit = 4'd3;
      7'b0110011: digit = 4'd4;
      7'b1011011: digit = 4'd5;
      7'b1011111: digit = 4'd6;
      7'b1110000: digit = 4'd7;
      7'b1111111: digit = 4'd8;
      7'b1111011: digit = 4'd9;
      default:    digit = 4'd0;
    endcase
    seg_to_ascii = CHAR_ZERO | BYTE_W'(digit);
  endfunction

  assign asciOutHigh = seg_to_ascii(ssIn[2*SEG_W-1:SEG_W]);
  assign asciOutLow  = seg_to_ascii(ssIn[SEG_W-1:0]);

endmodule

// File: rtl/floor_report_tx.sv
// Floor-number reporter: snapshots the segment bus on change or on a forced
// request and streams PREFIX, high digit, low digit [, CR, LF] over a
// valid/ready byte interface, then enforces an idle gap between frames.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   ssIn        - 14-bit two-digit segment bus
//   forceReq    - one-cycle request for a frame even if ssIn is unchanged
//   txData      - byte toward the transmitter
//   txValid     - txData valid
//   txReady     - transmitter accepts when txValid && txReady
//   busy        - high whenever the framer is not idle
//   frameCount  - completed frames, wrapping
module floor_report_tx
  import floor_report_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PREFIX     = 8'h46,
  parameter bit                SEND_CRLF  = 1'b1,
  parameter int unsigned       GAP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*SEG_W-1:0]  ssIn,
  input  logic                forceReq,
  output logic [BYTE_W-1:0]   txData,
  output logic                txValid,
  input  logic                txReady,
  output logic                busy,
  output logic [BYTE_W-1:0]   frameCount
);

  localparam logic [IDX_W-1:0] LAST_IDX = SEND_CRLF ? IDX_LF : IDX_LOW;
  // Only reached when GAP_CYCLES > 0, so the wrap for zero is harmless.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t              state;
  logic                pending;
  logic [2*SEG_W-1:0]  prev_ss;
  logic [2*SEG_W-1:0]  snapshot;
  logic [IDX_W-1:0]    idx;
  logic [GAP_W-1:0]    gap_cnt;
  logic [BYTE_W-1:0]   asci_high;
  logic [BYTE_W-1:0]   asci_low;
  logic                req_c;
  logic                accept_c;

  segment_encoder u_enc (
    .ssIn        (snapshot),
    .asciOutHigh (asci_high),
    .asciOutLow  (asci_low)
  );

  // A change and a force in the same cycle form a single request.
  assign req_c    = (ssIn != prev_ss) || forceReq;
  assign accept_c = txValid && txReady;

  // Framer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      prev_ss    <= '0;
      snapshot   <= '0;
      idx        <= IDX_PREFIX;
      gap_cnt    <= '0;
      txData     <= '0;
      txValid    <= 1'b0;
      busy       <= 1'b0;
      frameCount <= '0;
    end else begin
      if (req_c) prev_ss <= ssIn;
      case (state)
        IDLE: begin
          if (pending || req_c) begin
            snapshot <= ssIn;
            pending  <= 1'b0;
            idx      <= IDX_PREFIX;
            txData   <= PREFIX;
            txValid  <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (req_c) pending <= 1'b1;
          if (accept_c) begin
            if (idx == LAST_IDX) begin
              txValid    <= 1'b0;
              frameCount <= frameCount + 8'd1;
              gap_cnt    <= '0;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
              end
            end else begin
              // Snapshot is already stable here, so the next byte is registered directly.
              idx    <= idx + 3'd1;
              txData <= frame_byte(idx + 3'd1, PREFIX, asci_high, asci_low);
            end
          end
        end
        GAP: begin
          if (req_c) pending <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
